// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency SRAM among NumPorts requesters.
// Grants are issued combinationally in the request cycle. Responses (rvalid) follow one cycle
// later. Read data is passed straight through from the SRAM.
// Optional feature: define SRAM_RR_ARBITER_LOCK_EN to add lock_i. A port that is granted while
// locked keeps priority for up to MaxLockCycles consecutive grants.
module sram_rr_arbiter #(
    parameter int unsigned NumPorts      = 2,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned AddrWidth     = 25,
    parameter int unsigned MaxLockCycles = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPorts-1:0]               req_i,
    input  logic [NumPorts-1:0]               we_i,
    input  logic [NumPorts*AddrWidth-1:0]     addr_i,
    input  logic [NumPorts*(DataWidth/8)-1:0] be_i,
    input  logic [NumPorts*DataWidth-1:0]     wdata_i,
`ifdef SRAM_RR_ARBITER_LOCK_EN
    input  logic [NumPorts-1:0]               lock_i,
`endif
    output logic [NumPorts-1:0]               gnt_o,
    output logic [NumPorts-1:0]               rvalid_o,
    output logic [DataWidth-1:0]              rdata_o,
    output logic                              mem_req_o,
    output logic                              mem_we_o,
    output logic [AddrWidth-1:0]              mem_addr_o,
    output logic [DataWidth/8-1:0]            mem_be_o,
    output logic [DataWidth-1:0]              mem_wdata_o,
    input  logic [DataWidth-1:0]              mem_rdata_i
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned PtrW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    // Reject parameter sets the datapath cannot represent
    if (NumPorts < 2 || (DataWidth % 8) != 0 || MaxLockCycles < 1) begin : g_bad_params
        $error("sram_rr_arbiter: illegal parameter combination");
    end

    logic [PtrW-1:0]     prio_q, prio_d;
    logic [NumPorts-1:0] rvalid_q;
    logic                gnt_any;
    logic [PtrW-1:0]     gnt_idx;
    logic [PtrW-1:0]     gnt_next;

`ifdef SRAM_RR_ARBITER_LOCK_EN
    localparam int unsigned LockCntW = $clog2(MaxLockCycles + 1);
    logic [LockCntW-1:0] lock_cnt_q, lock_cnt_d;
`endif

    // Priority scan: first requester at or above prio_q, wrapping modulo NumPorts
    always_comb begin : p_scan
        logic [PtrW:0] idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            idx = {1'b0, prio_q} + (PtrW+1)'(i);
            if (idx >= (PtrW+1)'(NumPorts)) begin
                idx = idx - (PtrW+1)'(NumPorts);
            end
            // Reset suppresses all grants so no access starts while rst_i is high
            if (!gnt_any && req_i[idx[PtrW-1:0]] && !rst_i) begin
                gnt_any = 1'b1;
                gnt_idx = idx[PtrW-1:0];
            end
        end
    end

    // One-hot grant and the port after the granted one
    always_comb begin : p_gnt
        logic [PtrW:0] nxt;
        gnt_o = '0;
        if (gnt_any) begin
            gnt_o[gnt_idx] = 1'b1;
        end
        nxt = {1'b0, gnt_idx} + (PtrW+1)'(1);
        if (nxt >= (PtrW+1)'(NumPorts)) begin
            nxt = '0;
        end
        gnt_next = nxt[PtrW-1:0];
    end

    // SRAM request mux; unused fields are driven 0 when idle
    always_comb begin
        mem_req_o   = gnt_any;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (gnt_any) begin
            mem_we_o    = we_i[gnt_idx];
            mem_addr_o  = addr_i[int'(gnt_idx) * AddrWidth +: AddrWidth];
            mem_be_o    = be_i[int'(gnt_idx) * BeWidth +: BeWidth];
            mem_wdata_o = wdata_i[int'(gnt_idx) * DataWidth +: DataWidth];
        end
    end

    // Next priority pointer (and lock run counter when enabled)
    always_comb begin
        prio_d = prio_q;
`ifdef SRAM_RR_ARBITER_LOCK_EN
        lock_cnt_d = '0;
        if (gnt_any) begin : b_lock
            logic [LockCntW-1:0] base;
            // A running lock count belongs to the port parked at prio_q
            base = (gnt_idx == prio_q) ? lock_cnt_q : '0;
            if (lock_i[gnt_idx] && base < LockCntW'(MaxLockCycles - 1)) begin
                prio_d     = gnt_idx;
                lock_cnt_d = base + LockCntW'(1);
            end else begin
                prio_d = gnt_next;
            end
        end
`else
        if (gnt_any) begin
            prio_d = gnt_next;
        end
`endif
    end

    // State registers; reset also drops any in-flight response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q   <= '0;
            rvalid_q <= '0;
        end else begin
            prio_q   <= prio_d;
            rvalid_q <= gnt_o;
        end
    end

`ifdef SRAM_RR_ARBITER_LOCK_EN
    // Lock run counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    assign rvalid_o = rvalid_q;
    assign rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter with a behavioural SRAM and a response scoreboard.
module tb_sram_rr_arbiter;

    localparam int unsigned NP  = 2;
    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 25;
    localparam int unsigned BW  = DW / 8;
    localparam int unsigned MLC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req;
    logic [NP-1:0]     we;
    logic [NP*AW-1:0]  addr;
    logic [NP*BW-1:0]  be;
    logic [NP*DW-1:0]  wdata;
`ifdef SRAM_RR_ARBITER_LOCK_EN
    logic [NP-1:0]     lock;
`endif
    logic [NP-1:0]     gnt;
    logic [NP-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [BW-1:0]     mem_be;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [NP-1:0] oh;
        bit            is_read;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [DW-1:0] sram [256];
    logic [DW-1:0] refm [256];

    always #5 clk = ~clk;

    sram_rr_arbiter #(
        .NumPorts     (NP),
        .DataWidth    (DW),
        .AddrWidth    (AW),
        .MaxLockCycles(MLC)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .be_i       (be),
        .wdata_i    (wdata),
`ifdef SRAM_RR_ARBITER_LOCK_EN
        .lock_i     (lock),
`endif
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_be_o   (mem_be),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    function automatic logic [DW-1:0] apply_be(logic [DW-1:0] old, logic [DW-1:0] d,
                                               logic [BW-1:0] b);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++) begin
            if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Behavioural single-port SRAM, read data valid the cycle after the request
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                sram[mem_addr[7:0]] = apply_be(sram[mem_addr[7:0]], mem_wdata, mem_be);
            end else begin
                mem_rdata <= sram[mem_addr[7:0]];
            end
        end
    end

    // Scoreboard consumer: each grant expects exactly one response on the next cycle
    always @(posedge clk) begin
        exp_t e;
        #3;
        checks++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rvalid !== e.oh) begin
                failures++;
                $display("FAIL rvalid: got %b expected %b at %0t", rvalid, e.oh, $time);
            end
            if (e.is_read) begin
                checks++;
                if (rdata !== e.data) begin
                    failures++;
                    $display("FAIL rdata: got %h expected %h at %0t", rdata, e.data, $time);
                end
            end
        end else if (rvalid !== '0) begin
            failures++;
            $display("FAIL rvalid_idle: got %b expected 0 at %0t", rvalid, $time);
        end
    end

    task automatic clear_inputs();
        req   = '0;
        we    = '0;
        addr  = '0;
        be    = '0;
        wdata = '0;
`ifdef SRAM_RR_ARBITER_LOCK_EN
        lock  = '0;
`endif
    endtask

    task automatic drive(int k, bit w, logic [AW-1:0] a, logic [BW-1:0] b, logic [DW-1:0] d);
        req[k]             = 1'b1;
        we[k]              = w;
        addr[k*AW +: AW]   = a;
        be[k*BW +: BW]     = b;
        wdata[k*DW +: DW]  = d;
    endtask

    task automatic cycle_start();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic idle_cycle();
        cycle_start();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push(logic [NP-1:0] oh, bit rd, logic [DW-1:0] d);
        exp_t e;
        e.oh      = oh;
        e.is_read = rd;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        cycle_start();
        rst = 1'b1;
        drive(0, 1'b0, 25'h10, '1, '0);
        drive(1, 1'b0, 25'h20, '1, '0);
        @(negedge clk);
        checks += 3;
        if (gnt !== '0) begin
            failures++;
            $display("FAIL reset_gnt: got %b expected 00", gnt);
        end
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem_req: got %b expected 0", mem_req);
        end
        if (rvalid !== '0) begin
            failures++;
            $display("FAIL reset_rvalid: got %b expected 00", rvalid);
        end
        cycle_start();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d;
        do_reset();
        d = 64'hDEADBEEF_CAFEF00D;
        cycle_start();
        drive(0, 1'b1, 25'h10, 8'hFF, d);
        @(negedge clk);
        checks += 4;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL wr_gnt: got %b expected 01", gnt);
        end
        if (mem_we !== 1'b1 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL wr_mem_we: got we=%b req=%b expected 1 1", mem_we, mem_req);
        end
        if (mem_addr !== 25'h10) begin
            failures++;
            $display("FAIL wr_mem_addr: got %h expected 10", mem_addr);
        end
        if (mem_wdata !== d) begin
            failures++;
            $display("FAIL wr_mem_wdata: got %h expected %h", mem_wdata, d);
        end
        push(2'b01, 1'b0, '0);
        refm[8'h10] = apply_be(refm[8'h10], d, 8'hFF);

        cycle_start();
        drive(0, 1'b0, 25'h10, 8'hFF, '0);
        @(negedge clk);
        checks += 2;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL rd_gnt: got %b expected 01", gnt);
        end
        if (mem_we !== 1'b0) begin
            failures++;
            $display("FAIL rd_mem_we: got %b expected 0", mem_we);
        end
        push(2'b01, 1'b1, refm[8'h10]);
        idle_cycle();
    endtask

    task automatic test_alternate();
        logic [NP-1:0] exp_g;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle_start();
            drive(0, 1'b0, 25'h40, '1, '0);
            drive(1, 1'b0, 25'h41, '1, '0);
            @(negedge clk);
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (gnt !== exp_g) begin
                failures++;
                $display("FAIL alt_gnt[%0d]: got %b expected %b", i, gnt, exp_g);
            end
            push(exp_g, 1'b1, (i % 2 == 0) ? refm[8'h40] : refm[8'h41]);
        end
        idle_cycle();
    endtask

    task automatic test_single_port1();
        for (int i = 0; i < 4; i++) begin
            cycle_start();
            drive(1, 1'b0, 25'h50 + 25'(i), '1, '0);
            @(negedge clk);
            checks++;
            if (gnt !== 2'b10) begin
                failures++;
                $display("FAIL p1_gnt[%0d]: got %b expected 10", i, gnt);
            end
            push(2'b10, 1'b1, refm[8'h50 + 8'(i)]);
        end
        // Pointer must have wrapped back to port 0
        cycle_start();
        drive(0, 1'b0, 25'h60, '1, '0);
        drive(1, 1'b0, 25'h61, '1, '0);
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL p1_wrap_gnt: got %b expected 01", gnt);
        end
        push(2'b01, 1'b1, refm[8'h60]);
        idle_cycle();
    endtask

    task automatic test_byte_enable();
        logic [DW-1:0] d;
        cycle_start();
        drive(1, 1'b1, 25'h30, 8'hFF, '1);
        @(negedge clk);
        push(2'b10, 1'b0, '0);
        refm[8'h30] = apply_be(refm[8'h30], '1, 8'hFF);

        d = 64'h11223344_55667788;
        cycle_start();
        drive(1, 1'b1, 25'h30, 8'h0F, d);
        @(negedge clk);
        checks += 2;
        if (gnt !== 2'b10) begin
            failures++;
            $display("FAIL be_gnt: got %b expected 10", gnt);
        end
        if (mem_be !== 8'h0F) begin
            failures++;
            $display("FAIL be_mem_be: got %h expected 0f", mem_be);
        end
        push(2'b10, 1'b0, '0);
        refm[8'h30] = apply_be(refm[8'h30], d, 8'h0F);

        cycle_start();
        drive(1, 1'b0, 25'h30, 8'hFF, '0);
        @(negedge clk);
        push(2'b10, 1'b1, refm[8'h30]);
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle_start();
        drive(0, 1'b0, 25'h10, '1, '0);
        @(negedge clk);
        push(2'b01, 1'b1, refm[8'h10]);

        // Granted read whose response must be killed by reset
        cycle_start();
        drive(0, 1'b0, 25'h10, '1, '0);
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_gnt: got %b expected 01", gnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rvalid !== '0) begin
            failures++;
            $display("FAIL rstmid_rvalid: got %b expected 00", rvalid);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        drive(0, 1'b0, 25'h10, '1, '0);
        drive(1, 1'b0, 25'h20, '1, '0);
        #1;
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_prio: got %b expected 01", gnt);
        end
        push(2'b01, 1'b1, refm[8'h10]);
        idle_cycle();
    endtask

`ifdef SRAM_RR_ARBITER_LOCK_EN
    task automatic test_lock();
        logic [NP-1:0] exp_g;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle_start();
            lock[0] = 1'b1;
            drive(0, 1'b0, 25'h70, '1, '0);
            drive(1, 1'b0, 25'h71, '1, '0);
            @(negedge clk);
            exp_g = (i < 4) ? 2'b01 : 2'b10;
            checks++;
            if (gnt !== exp_g) begin
                failures++;
                $display("FAIL lock_gnt[%0d]: got %b expected %b", i, gnt, exp_g);
            end
            push(exp_g, 1'b1, (i < 4) ? refm[8'h70] : refm[8'h71]);
        end
        idle_cycle();
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            sram[i] = {32'hA5A5_0000 | 32'(i), ~32'(i)};
            refm[i] = {32'hA5A5_0000 | 32'(i), ~32'(i)};
        end
        test_reset();
        test_write_read();
        test_alternate();
        test_single_port1();
        test_byte_enable();
        test_reset_mid();
`ifdef SRAM_RR_ARBITER_LOCK_EN
        test_lock();
`endif
        idle_cycle();
        idle_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Shares one single-port, 1-cycle-latency SRAM among NumPorts word-level requesters, e.g. the AXI-to-memory bridge plus a preload/debug loader.
- Sits between the requesters and the SRAM macro inside the simulation main-memory subsystem.
- Round-robin arbitration with same-cycle grant; per-port read/write response one cycle after grant.

Parameters:
- NumPorts, 2, number of requesters (>=2).
- DataWidth, 64, SRAM word width in bits (multiple of 8).
- AddrWidth, 25, word address width (log2 of word count).
- MaxLockCycles, 16, longest consecutive grant run a locking port may hold (lock feature only).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  NumPorts  per-port request.
- we_i  in  NumPorts  per-port write enable.
- addr_i  in  NumPorts*AddrWidth  per-port word address; port k in slice k.
- be_i  in  NumPorts*DataWidth/8  per-port byte enables.
- wdata_i  in  NumPorts*DataWidth  per-port write data.
- gnt_o  out  NumPorts  one-hot grant, same cycle as req.
- rvalid_o  out  NumPorts  one-hot response, cycle after grant.
- rdata_o  out  DataWidth  read data, broadcast to all ports.
- mem_req_o  out  1  SRAM request.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  AddrWidth  SRAM word address.
- mem_be_o  out  DataWidth/8  SRAM byte enables.
- mem_wdata_o  out  DataWidth  SRAM write data.
- mem_rdata_i  in  DataWidth  SRAM read data, valid the cycle after mem_req_o.

Behaviour:
- State:
  - prio_q: index of the highest-priority port, reset 0.
  - rvalid_q: NumPorts bits, reset 0.
  - lock_cnt_q: reset 0 (lock feature only).
- Grant (combinational): scan ports from prio_q upward, wrapping modulo NumPorts. The first port with req_i high gets gnt_o[k]=1. At most one gnt bit is set per cycle.
- mem_req_o = |gnt_o. The mem_we/addr/be/wdata outputs mux the granted port's inputs.
  - With no grant, mem_we_o=0 and the other mem fields are don't-care, driven 0.
- Pointer update: on a grant to port k, prio_q <= (k+1) mod NumPorts. With no request, prio_q holds.
- Response:
  - rvalid_q <= gnt_o each cycle, so rvalid_o[k] rises exactly 1 cycle after gnt_o[k], for reads and writes.
  - rdata_o = mem_rdata_i. It is meaningful only when the rvalid bit belongs to a read; it is passed through, not registered.
- Throughput: one access per cycle. Back-to-back grants are legal; rvalid tracks the grant pipeline one cycle behind.
- Handshake:
  - A requester holds req and its payload stable until it sees gnt.
  - Dropping req before gnt is legal; no access occurs.
  - Requesters must not depend on gnt to decide whether to assert req; no combinational loop is allowed.
- Reset:
  - While rst_i=1: gnt_o=0, mem_req_o=0, rvalid_o=0, prio_q=0.
  - Reset asserted mid-operation clears rvalid_q immediately (asynchronous). The in-flight response is lost and requesters re-issue.
- Boundary cases:
  - All ports requesting continuously: grants rotate 0,1,...,N-1,0.
  - A single requester is granted every cycle.
  - prio_q wraps from NumPorts-1 to 0.

Optional Feature:
- Macro: SRAM_RR_ARBITER_LOCK_EN.
- Enabled:
  - Adds input port lock_i (NumPorts). A port granted while lock_i[k]=1 keeps priority: prio_q is not advanced, and lock_cnt_q increments per consecutive grant to k.
  - When lock_cnt_q reaches MaxLockCycles-1 on a grant, or the port is granted without lock, or it drops req, lock_cnt_q <= 0 and prio_q advances to (k+1) mod N as normal.
  - Guarantees other ports are served within MaxLockCycles+NumPorts-1 cycles.
- Disabled: lock_i absent, lock_cnt_q removed, pure round-robin.

Test Plan:
- Reset release, port0 write addr=0x10 be=0xFF data=0xDEADBEEF_CAFEF00D, then read 0x10 -> gnt_o=01 on the request cycle; read rvalid_o=01 next cycle with rdata_o=0xDEADBEEF_CAFEF00D.
- Ports 0 and 1 both request reads for 6 cycles from reset -> gnt sequence 01,10,01,10,01,10; rvalid_o follows one cycle later each time.
- Only port1 requests for 4 cycles -> gnt_o=10 every cycle, 4 rvalid pulses, prio_q settles to 0.
- Byte-enable write be=0x0F data=0x11223344_55667788 over an all-0xFF word, then read -> 0xFFFFFFFF_55667788.
- Assert rst_i for 1 cycle while a read is granted -> rvalid_o stays 0 afterwards; next grant goes to port0 regardless of the prior pointer.
- With SRAM_RR_ARBITER_LOCK_EN, MaxLockCycles=4, port0 locked and port1 requesting -> gnt sequence 01,01,01,01,10.
